// File: rtl/icache_direct_if.sv
// Fetch-side and refill-side signal bundle for icache_direct.
// The cache is the slave; the core plus memory model act as the master.
interface icache_direct_if;
  logic         proc_read;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_rdata;
  logic         proc_stall;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_addr, mem_rdata, mem_ready,
    output proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_addr, mem_rdata, mem_ready,
    input  proc_rdata, proc_stall, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/icache_direct.sv
// Direct-mapped read-only instruction cache: 0-cycle hits from 128-bit lines,
// single-line refill per miss, saturating hit/miss counters.
module icache_direct #(
  parameter int unsigned NUM_BLOCKS = 8,
  parameter int unsigned CNT_W      = 16
) (
  input  logic             clk,
  input  logic             proc_reset,
  icache_direct_if.slave   bus,
  output logic [CNT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt
);
  localparam int unsigned IDX_W = $clog2(NUM_BLOCKS);
  localparam int unsigned TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, REFILL, DONE} state_t;

  state_t                 state;
  logic [NUM_BLOCKS-1:0]  valid;
  logic [TAG_W-1:0]       tags  [NUM_BLOCKS];
  logic [127:0]           lines [NUM_BLOCKS];

  logic [IDX_W-1:0]       idx;
  logic [TAG_W-1:0]       tag;
  logic [1:0]             offset;
  logic [127:0]           line_sel;
  logic [31:0]            word_sel;
  logic                   hit;
  logic                   accept_hit;
  logic                   start_miss;
  logic                   fill;
  logic [IDX_W-1:0]       fill_idx;
  logic [TAG_W-1:0]       fill_tag;

  assign offset = bus.proc_addr[1:0];
  assign idx    = bus.proc_addr[IDX_W+1:2];
  assign tag    = bus.proc_addr[29:IDX_W+2];

  assign line_sel = lines[idx];
  assign hit      = valid[idx] && (tags[idx] == tag);

  always_comb begin
    word_sel = '0;
    case (offset)
      2'd0: word_sel = line_sel[31:0];
      2'd1: word_sel = line_sel[63:32];
      2'd2: word_sel = line_sel[95:64];
      2'd3: word_sel = line_sel[127:96];
      default: word_sel = '0;
    endcase
  end

  assign accept_hit = (state == IDLE) && bus.proc_read && hit;
  assign start_miss = (state == IDLE) && bus.proc_read && !hit;
  assign fill       = (state == REFILL) && bus.mem_ready;

  // mem_addr doubles as the latched miss address, so the refill target
  // cannot follow proc_addr once the miss has been taken.
  assign fill_idx = bus.mem_addr[IDX_W-1:0];
  assign fill_tag = bus.mem_addr[27:IDX_W];

  assign bus.proc_stall = (state != IDLE) || (bus.proc_read && !hit);
  assign bus.proc_rdata = bus.proc_read ? word_sel : '0;
  assign bus.mem_write  = 1'b0;
  assign bus.mem_wdata  = '0;

  always_ff @(posedge clk or posedge proc_reset) begin
    if (proc_reset) begin
      state        <= IDLE;
      valid        <= '0;
      bus.mem_read <= 1'b0;
      bus.mem_addr <= '0;
      hit_cnt      <= '0;
      miss_cnt     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept_hit && (hit_cnt != '1)) begin
            hit_cnt <= hit_cnt + 1'b1;
          end
          if (start_miss) begin
            bus.mem_addr <= bus.proc_addr[29:2];
            bus.mem_read <= 1'b1;
            state        <= REFILL;
            if (miss_cnt != '1) begin
              miss_cnt <= miss_cnt + 1'b1;
            end
          end
        end
        REFILL: begin
          if (bus.mem_ready) begin
            valid[fill_idx] <= 1'b1;
            bus.mem_read    <= 1'b0;
            state           <= DONE;
          end
        end
        DONE: begin
          bus.mem_read <= 1'b0;
          state        <= IDLE;
        end
        default: begin
          bus.mem_read <= 1'b0;
          state        <= IDLE;
        end
      endcase
    end
  end

  // Tag and data storage carry no reset; valid bits gate their use.
  always_ff @(posedge clk) begin
    if (fill) begin
      lines[fill_idx] <= bus.mem_rdata;
      tags[fill_idx]  <= fill_tag;
    end
  end
endmodule

// File: tb/tb_icache_direct.sv
// Randomized self-checking bench for icache_direct against a line-level
// cache model (valid/tag/data arrays plus saturating counters).
module tb_icache_direct;
  logic        clk;
  logic        proc_reset;
  logic [15:0] hit_cnt;
  logic [15:0] miss_cnt;

  icache_direct_if bus ();

  icache_direct #(.NUM_BLOCKS(8), .CNT_W(16)) dut (
    .clk        (clk),
    .proc_reset (proc_reset),
    .bus        (bus),
    .hit_cnt    (hit_cnt),
    .miss_cnt   (miss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  bit           ref_valid [8];
  logic [24:0]  ref_tag   [8];
  logic [127:0] ref_line  [8];
  int unsigned  ref_hits;
  int unsigned  ref_misses;

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit ref_is_hit(input logic [29:0] a);
    return ref_valid[a[4:2]] && (ref_tag[a[4:2]] == a[29:5]);
  endfunction

  function automatic logic [31:0] ref_word(input logic [29:0] a);
    logic [127:0] l;
    l = ref_line[a[4:2]];
    return l[32*a[1:0] +: 32];
  endfunction

  function automatic logic [127:0] rand_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic ref_clear();
    for (int i = 0; i < 8; i++) ref_valid[i] = 1'b0;
    ref_hits   = 0;
    ref_misses = 0;
  endtask

  task automatic idle_cycle();
    @(negedge clk);
    bus.proc_read = 1'b0;
    bus.proc_addr = 30'($urandom);
    #1;
    check("idle_stall", bus.proc_stall, 1'b0);
    check("idle_rdata", bus.proc_rdata, 32'h0);
    check("mem_write", {bus.mem_write, bus.mem_wdata}, '0);
  endtask

  // One fetch; on a miss, runs the refill with lat REFILL cycles before
  // mem_ready and returns once the cache is back in IDLE.
  task automatic fetch(input logic [29:0] addr, input int unsigned lat,
                       input logic [127:0] line, input bit use_alt,
                       input logic [29:0] alt);
    @(negedge clk);
    bus.proc_read = 1'b1;
    bus.proc_addr = addr;
    #1;
    if (ref_is_hit(addr)) begin
      check("hit_stall", bus.proc_stall, 1'b0);
      check("hit_rdata", bus.proc_rdata, ref_word(addr));
      @(posedge clk);
      #1;
      if (ref_hits < 65535) ref_hits++;
      check("hit_cnt", hit_cnt, ref_hits);
      check("hit_mem_read", bus.mem_read, 1'b0);
    end else begin
      check("miss_stall", bus.proc_stall, 1'b1);
      @(posedge clk);
      #1;
      if (ref_misses < 65535) ref_misses++;
      check("miss_mem_read", bus.mem_read, 1'b1);
      check("miss_mem_addr", bus.mem_addr, addr[29:2]);
      check("miss_cnt", miss_cnt, ref_misses);
      for (int i = 0; i < int'(lat); i++) begin
        @(negedge clk);
        if (use_alt) bus.proc_addr = alt;
        @(posedge clk);
        #1;
        check("refill_mem_read", bus.mem_read, 1'b1);
        check("refill_mem_addr", bus.mem_addr, addr[29:2]);
        check("refill_stall", bus.proc_stall, 1'b1);
      end
      @(negedge clk);
      if (use_alt) bus.proc_addr = alt;
      bus.mem_ready = 1'b1;
      bus.mem_rdata = line;
      @(posedge clk);
      #1;
      bus.mem_ready = 1'b0;
      bus.mem_rdata = rand_line();
      ref_valid[addr[4:2]] = 1'b1;
      ref_tag[addr[4:2]]   = addr[29:5];
      ref_line[addr[4:2]]  = line;
      check("done_mem_read", bus.mem_read, 1'b0);
      check("done_stall", bus.proc_stall, 1'b1);
      @(posedge clk);
    end
  endtask

  task automatic fetch_simple(input logic [29:0] addr);
    fetch(addr, $urandom_range(0, 4), rand_line(), 1'b0, '0);
  endtask

  initial begin
    logic [29:0] a;
    proc_reset    = 1'b1;
    bus.proc_read = 1'b0;
    bus.proc_addr = '0;
    bus.mem_ready = 1'b0;
    bus.mem_rdata = '0;
    ref_clear();
    #2;
    check("rst_mem_read", bus.mem_read, 1'b0);
    check("rst_mem_addr", bus.mem_addr, 28'h0);
    check("rst_hit_cnt", hit_cnt, 16'h0);
    check("rst_miss_cnt", miss_cnt, 16'h0);
    check("rst_stall", bus.proc_stall, 1'b0);
    check("rst_rdata", bus.proc_rdata, 32'h0);
    @(negedge clk);
    proc_reset = 1'b0;

    // First miss, refill, then sequential hits across the line
    fetch(30'h0, 5, {32'h4, 32'h3, 32'h2, 32'h1}, 1'b0, '0);
    fetch(30'h0, 0, '0, 1'b0, '0);
    check("t1_rdata_model", ref_word(30'h0), 32'h1);
    fetch_simple(30'h1);
    fetch_simple(30'h2);
    fetch_simple(30'h3);
    check("t2_hit_cnt", hit_cnt, 16'd4);

    // Conflict on index 0, then re-miss of the evicted line
    fetch_simple(30'h20);
    fetch_simple(30'h20);
    fetch_simple(30'h0);
    check("t3_miss_cnt", miss_cnt, 16'd3);
    fetch_simple(30'h0);

    // Address change during refill must not redirect it
    fetch(30'h20, 3, rand_line(), 1'b1, 30'h44);
    fetch_simple(30'h44);
    fetch_simple(30'h44);
    fetch_simple(30'h20);

    // Reset in the middle of a refill
    @(negedge clk);
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h7C;
    @(posedge clk);
    #1;
    check("rr_mem_read_on", bus.mem_read, 1'b1);
    @(negedge clk);
    proc_reset = 1'b1;
    #1;
    ref_clear();
    check("rr_mem_read_off", bus.mem_read, 1'b0);
    check("rr_hit_cnt", hit_cnt, 16'h0);
    check("rr_miss_cnt", miss_cnt, 16'h0);
    @(negedge clk);
    proc_reset    = 1'b0;
    bus.proc_read = 1'b0;
    fetch_simple(30'h0);
    check("rr_refetch_miss", miss_cnt, 16'd1);
    fetch_simple(30'h0);

    // Randomized mix of hits, misses and conflicts over four tags
    for (int n = 0; n < 150; n++) begin
      a = 30'($urandom_range(0, 127));
      if ($urandom_range(0, 3) == 0) idle_cycle();
      fetch_simple(a);
      fetch_simple(a);
    end

    // Stray mem_ready outside REFILL must leave the array untouched
    @(negedge clk);
    bus.proc_read = 1'b0;
    bus.mem_ready = 1'b1;
    bus.mem_rdata = rand_line();
    @(negedge clk);
    bus.mem_ready = 1'b0;
    #1;
    check("stray_mem_read", bus.mem_read, 1'b0);
    for (int i = 0; i < 8; i++) fetch_simple(30'(i * 4));
    for (int i = 0; i < 8; i++) fetch_simple(30'(i * 4 + 1));

    // Drive hit_cnt into saturation and hold
    fetch_simple(30'h0);
    @(negedge clk);
    bus.proc_read = 1'b1;
    bus.proc_addr = 30'h0;
    repeat (65536) @(posedge clk);
    #1;
    ref_hits = 65535;
    check("sat_hit_cnt", hit_cnt, ref_hits);
    @(posedge clk);
    #1;
    check("sat_hold", hit_cnt, 16'hFFFF);
    check("sat_stall", bus.proc_stall, 1'b0);

    @(negedge clk);
    bus.proc_read = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
